// File: rtl/btb_pkg.sv
// Shared BTB definitions: way layout, field positions, widths and the 2-bit
// branch-direction counter encoding.
package btb_pkg;

    localparam int TAG_W  = 27;
    localparam int IDX_W  = 3;
    localparam int WAY_W  = 64;
    localparam int SET_W  = 2 * WAY_W;

    localparam int VALID_BIT = 63;
    localparam int TAG_HI    = 62;
    localparam int TAG_LO    = 36;
    localparam int TGT_HI    = 35;
    localparam int TGT_LO    = 4;
    localparam int ST_HI     = 3;
    localparam int ST_LO     = 2;

    typedef enum logic [1:0] {
        ST_SNT = 2'b00,
        ST_WNT = 2'b01,
        ST_WT  = 2'b10,
        ST_ST  = 2'b11
    } btb_state_t;

    typedef struct packed {
        logic                 valid;
        logic [TAG_W-1:0]     tag;
        logic [31:0]          target;
        btb_state_t           state;
        logic [1:0]           pad;
    } btb_way_t;

    // Pad bits are forced to zero so a way read back always has a canonical form.
    function automatic btb_way_t unpack_way(input logic [WAY_W-1:0] bits);
        btb_way_t w;
        w.valid  = bits[VALID_BIT];
        w.tag    = bits[TAG_HI:TAG_LO];
        w.target = bits[TGT_HI:TGT_LO];
        w.state  = btb_state_t'(bits[ST_HI:ST_LO]);
        w.pad    = 2'b00;
        return w;
    endfunction

endpackage

// File: rtl/btb_way_match.sv
// Combinational tag compare for one BTB way; reports hit, taken direction and
// the stored target.
module btb_way_match
    import btb_pkg::*;
(
    input  btb_way_t          i_way,
    input  logic [TAG_W-1:0]  i_tag,
    output logic              o_hit,
    output logic              o_taken,
    output logic [31:0]       o_target
);

    // Only the direction bit of the counter matters for prediction.
    logic [2:0] w_unused;
    assign w_unused = {i_way.state[0], i_way.pad};

    assign o_hit    = i_way.valid && (i_way.tag == i_tag);
    assign o_taken  = o_hit && i_way.state[1];
    assign o_target = i_way.target;

endmodule

// File: rtl/btb_lookup.sv
// IF-stage BTB read: 8-set x 2-way storage, per-set LRU bits and a registered
// prediction. Optional same-cycle write bypass under `BTB_RDW_BYPASS_EN.
module btb_lookup
    import btb_pkg::*;
#(
    parameter int          NUM_SETS        = 8,
    parameter logic [31:0] RESET_PC_TARGET = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lookup_valid,
    input  logic [31:0]       lookup_pc,
    input  logic              stall,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic [SET_W-1:0]  wr_set,
    input  logic              wr_lru,
    output logic              pred_valid,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    output logic [SET_W-1:0]  pred_set,
    output logic [IDX_W-1:0]  pred_index
);

    logic [SET_W-1:0]     r_array [NUM_SETS];
    logic [NUM_SETS-1:0]  r_lru;

    logic                 r_valid;
    logic                 r_hit;
    logic                 r_taken;
    logic [31:0]          r_target;
    logic [SET_W-1:0]     r_set;
    logic [IDX_W-1:0]     r_index;

    logic [IDX_W-1:0]     w_idx;
    logic [TAG_W-1:0]     w_tag;
    logic [SET_W-1:0]     w_rd_set;
    btb_way_t             w_way1;
    btb_way_t             w_way2;
    logic                 w_hit1;
    logic                 w_hit2;
    logic                 w_taken1;
    logic                 w_taken2;
    logic [31:0]          w_tgt1;
    logic [31:0]          w_tgt2;
    logic                 w_hit;
    logic                 w_taken;
    logic [31:0]          w_pc_plus4;
    logic [31:0]          w_target;
    logic                 w_capture;

    assign w_idx = lookup_pc[4:2];
    assign w_tag = lookup_pc[31:5];

`ifdef BTB_RDW_BYPASS_EN
    assign w_rd_set = (wr_en && (wr_index == w_idx)) ? wr_set : r_array[w_idx];
`else
    assign w_rd_set = r_array[w_idx];
`endif

    assign w_way1 = unpack_way(w_rd_set[2*WAY_W-1:WAY_W]);
    assign w_way2 = unpack_way(w_rd_set[WAY_W-1:0]);

    btb_way_match u_match_way1 (
        .i_way    (w_way1),
        .i_tag    (w_tag),
        .o_hit    (w_hit1),
        .o_taken  (w_taken1),
        .o_target (w_tgt1)
    );

    btb_way_match u_match_way2 (
        .i_way    (w_way2),
        .i_tag    (w_tag),
        .o_hit    (w_hit2),
        .o_taken  (w_taken2),
        .o_target (w_tgt2)
    );

    // A double hit is malformed but tolerated: way1 takes priority everywhere.
    assign w_hit      = w_hit1 || w_hit2;
    assign w_taken    = w_hit1 ? w_taken1 : w_taken2;
    assign w_pc_plus4 = lookup_pc + 32'd4;
    assign w_target   = w_taken ? (w_hit1 ? w_tgt1 : w_tgt2) : w_pc_plus4;
    assign w_capture  = lookup_valid && !stall && !flush;

    // Storage and LRU. The write-back LRU assignment comes last so it wins
    // over a lookup-driven update to the same set.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SETS; i++) begin
                r_array[i] <= '0;
            end
            r_lru <= '0;
        end else begin
            if (w_capture && w_hit) begin
                r_lru[w_idx] <= !w_hit1;
            end
            if (wr_en) begin
                r_array[wr_index] <= wr_set;
                r_lru[wr_index]   <= wr_lru;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_hit    <= 1'b0;
            r_taken  <= 1'b0;
            r_target <= RESET_PC_TARGET;
            r_set    <= '0;
            r_index  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (!stall) begin
            if (lookup_valid) begin
                r_valid  <= 1'b1;
                r_hit    <= w_hit;
                r_taken  <= w_taken;
                r_target <= w_target;
                r_set    <= w_rd_set;
                r_index  <= w_idx;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign pred_valid  = r_valid;
    assign pred_hit    = r_hit;
    assign pred_taken  = r_taken;
    assign pred_target = r_target;
    assign pred_set    = r_set;
    assign pred_index  = r_index;

endmodule

// File: tb/tb_btb_lookup.sv
// Directed self-checking bench for btb_lookup; expectations depend on
// whether `BTB_RDW_BYPASS_EN is defined.
module tb_btb_lookup;
    import btb_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              lookup_valid;
    logic [31:0]       lookup_pc;
    logic              stall;
    logic              flush;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_index;
    logic [SET_W-1:0]  wr_set;
    logic              wr_lru;
    logic              pred_valid;
    logic              pred_hit;
    logic              pred_taken;
    logic [31:0]       pred_target;
    logic [SET_W-1:0]  pred_set;
    logic [IDX_W-1:0]  pred_index;

    int n_checks = 0;
    int n_errors = 0;

    btb_lookup #(.NUM_SETS(8), .RESET_PC_TARGET(32'h0)) dut (
        .clk          (clk),
        .rst          (rst),
        .lookup_valid (lookup_valid),
        .lookup_pc    (lookup_pc),
        .stall        (stall),
        .flush        (flush),
        .wr_en        (wr_en),
        .wr_index     (wr_index),
        .wr_set       (wr_set),
        .wr_lru       (wr_lru),
        .pred_valid   (pred_valid),
        .pred_hit     (pred_hit),
        .pred_taken   (pred_taken),
        .pred_target  (pred_target),
        .pred_set     (pred_set),
        .pred_index   (pred_index)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers / drivers ----------------
    function automatic logic [63:0] mk_way(input logic v, input logic [31:0] pc,
                                           input logic [31:0] tgt, input logic [1:0] st);
        return {v, pc[31:5], tgt, st, 2'b00};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_lookup(input logic v, input logic [31:0] pc);
        lookup_valid = v;
        lookup_pc    = pc;
    endtask

    task automatic drive_write(input logic en, input logic [2:0] idx,
                               input logic [127:0] set, input logic lru);
        wr_en    = en;
        wr_index = idx;
        wr_set   = set;
        wr_lru   = lru;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_pred(input string tag, input logic v, input logic h, input logic t,
                              input logic [31:0] tgt, input logic [2:0] idx);
        check({tag, ".valid"},  128'(pred_valid),  128'(v));
        check({tag, ".hit"},    128'(pred_hit),    128'(h));
        check({tag, ".taken"},  128'(pred_taken),  128'(t));
        check({tag, ".target"}, 128'(pred_target), 128'(tgt));
        check({tag, ".index"},  128'(pred_index),  128'(idx));
    endtask

    logic [127:0] set0_a, set0_b, set1_dbl, set2, set3, set4;
    logic [31:0]  held_target;
    logic [127:0] held_set;

    initial begin
        set0_a   = {mk_way(1'b1, 32'h1000, 32'h2000, 2'b11), 64'h0};
        set0_b   = {mk_way(1'b1, 32'h1000, 32'h2000, 2'b01),
                    mk_way(1'b1, 32'h1020, 32'h3000, 2'b10)};
        set1_dbl = {mk_way(1'b1, 32'h1004, 32'h4000, 2'b11),
                    mk_way(1'b1, 32'h1004, 32'h5000, 2'b11)};
        set2     = {mk_way(1'b1, 32'h2008, 32'h6000, 2'b10), 64'h0};
        set3     = {mk_way(1'b1, 32'h300C, 32'h7000, 2'b11), 64'h0};
        set4     = {mk_way(1'b1, 32'h1010, 32'h8000, 2'b11), 64'h0};

        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drive_lookup(1'b0, 32'h0);
        drive_write(1'b0, 3'd0, '0, 1'b0);
        step(); step();

        check_pred("reset", 1'b0, 1'b0, 1'b0, 32'h0, 3'd0);
        check("reset.set", pred_set, 128'h0);
        check("reset.lru", 128'(dut.r_lru), 128'h0);
        rst = 1'b0;

        // Cold miss falls through to pc+4.
        drive_lookup(1'b1, 32'h0000_1000);
        step();
        check_pred("miss", 1'b1, 1'b0, 1'b0, 32'h0000_1004, 3'd0);

        // Write strongly-taken entry, then idle cycle drops pred_valid.
        drive_lookup(1'b0, 32'h0000_1000);
        drive_write(1'b1, 3'd0, set0_a, 1'b1);
        step();
        drive_write(1'b0, 3'd0, '0, 1'b0);
        check("idle.valid", 128'(pred_valid), 128'h0);
        check("wr.lru0", 128'(dut.r_lru[0]), 128'h1);

        drive_lookup(1'b1, 32'h0000_1000);
        step();
        check_pred("hit_taken", 1'b1, 1'b1, 1'b1, 32'h0000_2000, 3'd0);
        check("hit_taken.set", pred_set, set0_a);
        check("hit_way1.lru0", 128'(dut.r_lru[0]), 128'h0);

        // Weak not-taken in way1, weak taken in way2.
        drive_lookup(1'b0, 32'h0);
        drive_write(1'b1, 3'd0, set0_b, 1'b0);
        step();
        drive_write(1'b0, 3'd0, '0, 1'b0);
        drive_lookup(1'b1, 32'h0000_1000);
        step();
        check_pred("hit_nt", 1'b1, 1'b1, 1'b0, 32'h0000_1004, 3'd0);
        check("hit_nt.set", pred_set, set0_b);
        drive_lookup(1'b1, 32'h0000_1020);
        step();
        check_pred("hit_way2", 1'b1, 1'b1, 1'b1, 32'h0000_3000, 3'd0);
        check("hit_way2.lru0", 128'(dut.r_lru[0]), 128'h1);

        // Both ways hit: way1 wins.
        drive_lookup(1'b0, 32'h0);
        drive_write(1'b1, 3'd1, set1_dbl, 1'b1);
        step();
        drive_write(1'b0, 3'd0, '0, 1'b0);
        drive_lookup(1'b1, 32'h0000_1004);
        step();
        check_pred("dbl_hit", 1'b1, 1'b1, 1'b1, 32'h0000_4000, 3'd1);
        check("dbl_hit.lru1", 128'(dut.r_lru[1]), 128'h0);

        // PC+4 wraps at the top of the address space.
        drive_lookup(1'b1, 32'hFFFF_FFFC);
        step();
        check_pred("wrap", 1'b1, 1'b0, 1'b0, 32'h0000_0000, 3'd7);

        // Read-during-write to the same index.
        drive_lookup(1'b1, 32'h0000_2008);
        drive_write(1'b1, 3'd2, set2, 1'b0);
        step();
        drive_write(1'b0, 3'd0, '0, 1'b0);
`ifdef BTB_RDW_BYPASS_EN
        check_pred("rdw", 1'b1, 1'b1, 1'b1, 32'h0000_6000, 3'd2);
        check("rdw.set", pred_set, set2);
`else
        check_pred("rdw", 1'b1, 1'b0, 1'b0, 32'h0000_200C, 3'd2);
        check("rdw.set", pred_set, 128'h0);
`endif
        step();
        check_pred("rdw_repeat", 1'b1, 1'b1, 1'b1, 32'h0000_6000, 3'd2);

        // Hit in way1 (would clear LRU) concurrent with write-back LRU=1.
        drive_lookup(1'b1, 32'h0000_2008);
        drive_write(1'b1, 3'd2, set2, 1'b1);
        step();
        drive_write(1'b0, 3'd0, '0, 1'b0);
        check("lru_wb_wins", 128'(dut.r_lru[2]), 128'h1);

        // Capture a known prediction, then stall with changing PCs.
        drive_lookup(1'b1, 32'h0000_1000);
        step();
        check("pre_stall.lru0", 128'(dut.r_lru[0]), 128'h0);
        held_target = pred_target;
        held_set    = pred_set;
        stall = 1'b1;
        drive_lookup(1'b1, 32'h0000_1020);
        step();
        check_pred("stall1", 1'b1, 1'b1, 1'b0, 32'h0000_1004, 3'd0);
        drive_lookup(1'b1, 32'h0000_2008);
        step();
        check_pred("stall2", 1'b1, 1'b1, 1'b0, 32'h0000_1004, 3'd0);
        drive_lookup(1'b0, 32'hFFFF_FFFC);
        step();
        check_pred("stall3", 1'b1, 1'b1, 1'b0, 32'h0000_1004, 3'd0);
        check("stall.set", pred_set, set0_b);
        check("stall.lru0", 128'(dut.r_lru[0]), 128'h0);

        // Flush over stall; concurrent write-back still lands.
        flush = 1'b1;
        drive_lookup(1'b1, 32'h0000_300C);
        drive_write(1'b1, 3'd3, set3, 1'b1);
        step();
        flush = 1'b0; stall = 1'b0;
        drive_write(1'b0, 3'd0, '0, 1'b0);
        check("flush.valid", 128'(pred_valid), 128'h0);
        check("flush.lru3", 128'(dut.r_lru[3]), 128'h1);
        step();
        check_pred("post_flush", 1'b1, 1'b1, 1'b1, 32'h0000_7000, 3'd3);

        // Reset mid-stream with a pending write-back.
        rst = 1'b1;
        drive_lookup(1'b1, 32'h0000_1010);
        drive_write(1'b1, 3'd4, set4, 1'b1);
        step();
        rst = 1'b0;
        drive_write(1'b0, 3'd0, '0, 1'b0);
        check_pred("mid_reset", 1'b0, 1'b0, 1'b0, 32'h0, 3'd0);
        check("mid_reset.set", pred_set, 128'h0);
        check("mid_reset.lru", 128'(dut.r_lru), 128'h0);
        drive_lookup(1'b1, 32'h0000_1000);
        step();
        check_pred("post_reset_a", 1'b1, 1'b0, 1'b0, 32'h0000_1004, 3'd0);
        drive_lookup(1'b1, 32'h0000_1010);
        step();
        check_pred("post_reset_b", 1'b1, 1'b0, 1'b0, 32'h0000_1014, 3'd4);
        drive_lookup(1'b0, 32'h0);
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/btb_lookup.md
# btb_lookup

IF-stage read end of the branch target buffer: owns the 8-set × 2-way BTB storage and the per-set LRU bits. It looks up the fetch PC and returns a registered prediction one cycle later. It also accepts the EX-stage write-back (`write_set`, `next_LRU_write`) produced by the BTB update logic. Its registered read set is the `update_set` that travels down the pipeline to that update logic.

## Interface
Parameters:
- NUM_SETS, 8, number of sets; index width is log2(NUM_SETS) = 3.
- RESET_PC_TARGET, 32'h0, value driven on `pred_target` during reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- lookup_valid  in  1  fetch PC valid this cycle.
- lookup_pc  in  32  fetch PC; tag = [31:5], index = [4:2], [1:0] ignored.
- stall  in  1  hold the output register and suppress capture.
- flush  in  1  invalidate the output register.
- wr_en  in  1  commit a write-back from EX.
- wr_index  in  3  set being written.
- wr_set  in  128  full new set contents: way1 in [127:64], way2 in [63:0].
- wr_lru  in  1  new LRU bit for `wr_index`.
- pred_valid  out  1  prediction register holds a valid lookup.
- pred_hit  out  1  tag matched a valid way.
- pred_taken  out  1  hit and matched state[1] == 1.
- pred_target  out  32  predicted next PC.
- pred_set  out  128  set contents as read; forwarded to EX as `update_set`.
- pred_index  out  3  index of the lookup.

## Operation
- Way layout, 64 bits: valid[63], tag[62:36], target[35:4], state[3:2], pad[1:0] = 0.
- Set read: combinational from the array at `lookup_pc[4:2]`.
- Match: way_n hits when valid_n && tag_n == lookup_pc[31:5].
  - Both ways hit (illegal but tolerated): way1 wins.
- Predicted PC: matched target if taken, else lookup_pc + 4.
  - Addition is 32-bit and wraps: 32'hFFFFFFFC → 32'h0.
- Capture: when lookup_valid && !stall && !flush, register hit, taken, target, set and index; pred_valid ← 1.
- Idle: lookup_valid == 0 and no stall → pred_valid ← 0; the other outputs hold.
- LRU bit = 1 means way1 is the next victim.
  - Capture with a hit in way1 → LRU[index] ← 0.
  - Capture with a hit in way2 → LRU[index] ← 1.
  - Miss → LRU unchanged.
- Write-back: wr_en → array[wr_index] ← wr_set and LRU[wr_index] ← wr_lru.
  - Applies regardless of stall or flush.
- Same cycle, same index, wr_en and a lookup hit: the write-back LRU value wins.
- Flush: pred_valid ← 0 and no capture; array writes and the write-back LRU update still happen.
  - Flush wins over stall.
- Stall: all pred_* outputs hold; no lookup-driven LRU update.
- Reset: all 8 sets ← 0 (all ways invalid); LRU ← 8'h00.
  - pred_valid, pred_hit, pred_taken ← 0; pred_target ← RESET_PC_TARGET; pred_set ← 0; pred_index ← 0.
  - Reset overrides wr_en, flush and stall in the same cycle.

## Timing
- Lookup latency 1 cycle: PC presented in cycle N, prediction visible in N+1.
- Write-back visible to lookups from the cycle after wr_en.
  - Same-cycle read-during-write to the same index: see Configuration.
- No combinational path from any input to any output.
- Throughput one lookup per cycle when not stalled.

## Configuration
- `BTB_RDW_BYPASS_EN` defined:
  - wr_en && wr_index == lookup_pc[4:2] → the lookup uses wr_set instead of the array contents.
  - Match, prediction and pred_set all reflect the new data.
- Not defined: the lookup sees the pre-write contents; the new data is visible one cycle later.

## Structure
- Package `btb_pkg`:
  - Field-position localparams for valid, tag, target and state.
  - Way and set widths; TAG_W = 27, IDX_W = 3.
  - 2-bit state encoding: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.
  - A packed `btb_way_t` struct.
- Sub-module `btb_way_match`, instantiated twice: combinational. Takes one way and a tag; returns hit, taken and target.

## Test plan
- Reset, then lookup PC 32'h0000_1000 → N+1: pred_valid=1, pred_hit=0, pred_target=32'h0000_1004.
- Write index 0, way1 = {valid=1, tag=32'h1000>>5, target=32'h0000_2000, state=11}; lookup 32'h0000_1000 one cycle later → hit=1, taken=1, target=32'h0000_2000, LRU[0]=0.
- Same entry with state=01 → hit=1, taken=0, target=32'h0000_1004; pred_set equals the written set bit-exactly.
- wr_en to index 2 and lookup of index 2 in the same cycle:
  - macro defined → new data predicted.
  - macro undefined → old miss; a repeat lookup then hits.
- Stall for 3 cycles with changing PCs → outputs constant. Flush together with stall → pred_valid=0 next cycle; a concurrent wr_en still lands.
- rst asserted mid-stream with pending wr_en → all sets invalid, LRU=0, pred_valid=0; the next lookup of a previously written PC misses.
